// File: rtl/block_mem_burst_reader_pkg.sv
// Shared definitions for the block memory read-side requester: default widths,
// FSM state encodings and the retry counter width.
package block_mem_burst_reader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int RETRY_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STALL = 2'd3
  } rd_state_e;

endpackage

// File: rtl/block_mem_rd_fifo.sv
// Small synchronous FIFO buffering returned read words. The head is read from
// the register array and forced to zero while empty so it has a clean idle value.
module block_mem_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/block_mem_burst_reader.sv
// Burst read requester for one port of the block memory controller: walks a
// word range one read at a time, retries denied grants and streams data out.
module block_mem_burst_reader
  import block_mem_burst_reader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_enable,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // and its payload stay stable until accepted, and ready never waits on valid.

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              done_q;
  logic [RETRY_W-1:0] retry_q;

  logic              accept;
  logic              empty_cmd;
  logic              grant;
  logic              last_beat;
  logic              space_after;
  logic [CNT_W-1:0]  cnt_after;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_wdata;
  logic [DATA_W:0]   fifo_rdata;

  assign accept     = cmd_valid && (state_q == ST_IDLE);
  assign empty_cmd  = (cmd_len == '0);
  assign grant      = (state_q == ST_WAIT) && mem_rd_enable;
  assign last_beat  = (rem_q == LEN_W'(1));

  assign fifo_push  = grant;
  assign fifo_wdata = {last_beat, mem_rd_data};
  assign fifo_pop   = out_valid && out_ready;

  // Occupancy after the push being made this cycle, crediting a concurrent pop.
  assign cnt_after   = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);
  assign space_after = (cnt_after < DEPTH_C);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !empty_cmd) begin
          state_d = fifo_full ? ST_STALL : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rd_enable) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else if (space_after) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (!fifo_full) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (accept && empty_cmd) || (grant && last_beat);
      // An empty burst leaves the address untouched.
      if (accept && !empty_cmd) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (grant) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
      if ((state_q == ST_WAIT) && !mem_rd_enable && (retry_q != '1)) begin
        retry_q <= retry_q + RETRY_W'(1);
      end
    end
  end

  block_mem_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign retry_cnt   = retry_q;
  assign mem_rd_addr = addr_q;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_rdata[DATA_W-1:0];
  assign out_last    = fifo_rdata[DATA_W];
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_block_mem_burst_reader.sv
// Directed bench for block_mem_burst_reader: a memory responder with scripted
// grant denials, a read-address scoreboard and an output-word scoreboard.
module tb_block_mem_burst_reader;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_enable = 1'b0;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [15:0]       retry_cnt;
  logic [1:0]        state_dbg;

  int tests_run = 0;
  int fails     = 0;
  int done_cnt  = 0;
  int grant_cnt = 0;
  int deny_left = 0;
  logic              hold_chk = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;

  logic [DATA_W:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] mem_model [4096];

  block_mem_burst_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_enable (mem_rd_enable),
    .mem_rd_data   (mem_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .retry_cnt     (retry_cnt),
    .state_dbg     (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder and scoreboards, evaluated mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 64'({out_last, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("out_word", 64'({out_last, out_data}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (state_dbg == S_WAIT && !reset) begin
      if (deny_left > 0) begin
        mem_rd_enable = 1'b0;
        mem_rd_data   = 32'hDEAD_BEEF;
        deny_left--;
        if (hold_chk) check("hold_addr", 64'(mem_rd_addr), 64'(hold_addr));
      end else begin
        mem_rd_enable = 1'b1;
        mem_rd_data   = mem_model[mem_rd_addr];
        grant_cnt++;
        if (exp_addr_q.size() == 0) begin
          check("extra_read", 64'(mem_rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("rd_addr", 64'(mem_rd_addr), 64'(exp_addr_q[0]));
          void'(exp_addr_q.pop_front());
        end
      end
    end else begin
      mem_rd_enable = 1'b0;
      mem_rd_data   = '0;
    end
  end

  // Driver tasks: all called at posedge+1 and return at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_burst(input logic [ADDR_W-1:0] a, input int len);
    logic [ADDR_W-1:0] wa;
    for (int i = 0; i < len; i++) begin
      wa = a + ADDR_W'(i);
      exp_addr_q.push_back(wa);
      exp_q.push_back({(i == len - 1), mem_model[wa]});
    end
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(done_cnt - start), 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    check({tag, "_addr"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_retry"}, 64'(retry_cnt), 64'd0);
  endtask

  initial begin
    int g0;
    int d0;
    int n;

    for (int a = 0; a < 4096; a++) mem_model[a] = 32'hC0DE_0000 | 32'(a);
    mem_model[257] = 32'hAAAA_AAAA;
    mem_model[258] = 32'h0000_0001;
    mem_model[259] = 32'h0000_0002;

    // Reset
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Burst 257 x3, full grant, consumer always ready
    out_ready = 1'b1;
    exp_burst(12'd257, 3);
    send_cmd(12'd257, 8'd3);
    check("b1_issue_addr", 64'(mem_rd_addr), 64'd257);
    check("b1_busy", 64'(busy), 64'd1);
    check("b1_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("b1_wait_addr", 64'(mem_rd_addr), 64'd257);
    check("b1_valid_early", 64'(out_valid), 64'd0);
    tick();
    check("b1_first_valid", 64'(out_valid), 64'd1);
    check("b1_first_word", 64'({out_last, out_data}), 64'h0_AAAA_AAAA);
    repeat (3) tick();
    check("b1_done_early", 64'(done), 64'd0);
    check("b1_busy_late", 64'(busy), 64'd1);
    tick();
    check("b1_done", 64'(done), 64'd1);
    check("b1_busy_fall", 64'(busy), 64'd0);
    tick();
    check("b1_done_pulse", 64'(done), 64'd0);
    drain("b1_drain", 20);
    check("b1_retry", 64'(retry_cnt), 64'd0);

    // Single word at 15 with five denied grant cycles
    deny_left = 5;
    hold_chk  = 1'b1;
    hold_addr = 12'd15;
    d0 = done_cnt;
    exp_burst(12'd15, 1);
    send_cmd(12'd15, 8'd1);
    wait_done("b2_done", 50);
    hold_chk = 1'b0;
    drain("b2_drain", 20);
    check("b2_retry", 64'(retry_cnt), 64'd5);
    check("b2_done_once", 64'(done_cnt - d0), 64'd1);

    // Address wrap
    exp_burst(12'd4094, 4);
    send_cmd(12'd4094, 8'd4);
    wait_done("b3_done", 50);
    drain("b3_drain", 20);
    check("b3_next_addr", 64'(mem_rd_addr), 64'd2);

    // Backpressure fills the FIFO and stalls
    out_ready = 1'b0;
    g0 = grant_cnt;
    exp_burst(12'd100, 8);
    send_cmd(12'd100, 8'd8);
    repeat (20) tick();
    check("b4_reads", 64'(grant_cnt - g0), 64'd4);
    check("b4_state", 64'(state_dbg), 64'(S_STALL));
    check("b4_stall_addr", 64'(mem_rd_addr), 64'd104);
    check("b4_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done("b4_done", 100);
    drain("b4_drain", 20);
    check("b4_retry", 64'(retry_cnt), 64'd5);

    // Empty burst
    d0 = done_cnt;
    send_cmd(12'd777, 8'd0);
    check("b5_done", 64'(done), 64'd1);
    check("b5_busy", 64'(busy), 64'd0);
    check("b5_addr", 64'(mem_rd_addr), 64'd108);
    check("b5_valid", 64'(out_valid), 64'd0);
    tick();
    check("b5_done_pulse", 64'(done), 64'd0);
    check("b5_addr_after", 64'(mem_rd_addr), 64'd108);
    check("b5_valid_after", 64'(out_valid), 64'd0);
    check("b5_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Asynchronous reset while a read is pending and the FIFO holds data
    out_ready = 1'b0;
    g0 = grant_cnt;
    exp_burst(12'd50, 4);
    send_cmd(12'd50, 8'd4);
    n = 0;
    while (grant_cnt < g0 + 2 && n < 50) begin
      tick();
      n++;
    end
    check("b6_two_reads", 64'(grant_cnt - g0), 64'd2);
    deny_left = 1000;
    tick();
    check("b6_in_wait", 64'(state_dbg), 64'(S_WAIT));
    check("b6_fifo_held", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("b6_rst");
    exp_q.delete();
    exp_addr_q.delete();
    deny_left = 0;
    d0 = done_cnt;
    repeat (2) tick();
    check("b6_no_done", 64'(done_cnt - d0), 64'd0);
    check("b6_still_empty", 64'(out_valid), 64'd0);
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    exp_burst(12'd60, 2);
    send_cmd(12'd60, 8'd2);
    wait_done("b6_done", 50);
    drain("b6_drain", 20);
    check("b6_retry", 64'(retry_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
